misc_gen: RTL and testbench

MISC_GEN -- requirements
Module: misc_gen

---
 rtl/misc_gen_pkg.sv | 42 ++++
 rtl/misc_tick_cap.sv | 68 ++++++
 rtl/misc_gen.sv | 197 +++++++++++++++++++
 tb/tb_misc_gen.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/misc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : misc_gen_pkg
// Description : Shared definitions for the misc_gen block: Wishbone register
//               word addresses, BOOT/STATUS/PDM field positions and a
//               16-bit saturating increment helper used by the tick
//               capture channels.
// Revision    : 1.0 - initial release
// ============================================================================
package misc_gen_pkg;

    // Register word addresses
    localparam logic [7:0] c_addr_boot     = 8'h00;
    localparam logic [7:0] c_addr_status   = 8'h01;
    localparam logic [7:0] c_addr_time     = 8'h02;
    localparam logic [7:0] c_addr_sofcnt   = 8'h03;
    localparam logic [7:0] c_addr_cap_base = 8'h10;
    localparam logic [7:0] c_addr_pdm_base = 8'h20;

    // BOOT register fields
    localparam int c_boot_now_bit = 2;
    localparam int c_boot_sel_lsb = 0;

    // STATUS register: one sticky overflow flag per E1 port starting here
    localparam int c_status_ovf_lsb = 0;

    // PDM register: output-enable bit (value occupies the low bits)
    localparam int c_pdm_oe_bit = 31;

    // Interval counters and captures saturate at this value
    localparam logic [15:0] c_cnt_max = 16'hFFFF;

    // Add one (when inc is set) without wrapping past c_cnt_max.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic inc);
        if (inc && (v != c_cnt_max)) begin
            return v + 16'd1;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/misc_tick_cap.sv
`default_nettype none
// ============================================================================
// Module      : misc_tick_cap
// Description : One E1 tick capture channel. Counts ticks in a saturating
//               16-bit interval counter; on SOF the count (including a tick
//               in the same cycle) is copied to the capture register and the
//               counter restarts. A sticky overflow flag is set when the
//               counter reaches saturation and cleared by ovf_clr; a set in
//               the same cycle as a clear takes priority.
// Ports       : clk, rst_n      - clock, async active-low reset
//               tick            - single-cycle E1 bit tick
//               sof             - single-cycle USB start-of-frame
//               ovf_clr         - clear request for the overflow flag
//               cap[15:0]       - last captured interval count
//               ovf             - sticky overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module misc_tick_cap
    import misc_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        sof,
    input  logic        ovf_clr,
    output logic [15:0] cap,
    output logic        ovf
);

    logic [15:0] r_cnt;
    logic [15:0] r_cap;
    logic        r_ovf;

    logic [15:0] w_cnt_inc;
    logic        w_sat_set;

    assign w_cnt_inc = sat_inc16(r_cnt, tick);

    // Saturation is "reached" on the tick that moves the count onto the
    // maximum, whether or not an SOF restarts the counter in that cycle.
    assign w_sat_set = tick && (r_cnt == (c_cnt_max - 16'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_cap <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (sof) begin
                r_cap <= w_cnt_inc;
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_inc;
            end

            if (w_sat_set) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign cap = r_cap;
    assign ovf = r_ovf;

endmodule
`default_nettype wire

// File: rtl/misc_gen.sv
`default_nettype none
// ============================================================================
// Module      : misc_gen
// Description : Miscellaneous control/status block with a Wishbone slave.
//               Provides reboot request fields, per-port E1 tick interval
//               captures with sticky overflow flags, a free-running cycle
//               counter, a USB SOF counter and PDM channel configuration.
//               Every access is acked one cycle after wb_cyc rises; writes
//               land one cycle after the ack via registered strobes.
// Options     : MISC_GEN_PDM_READBACK_EN - when defined, PDM_i registers are
//               readable as {oe, zeros, value}; otherwise they read as 0 and
//               no PDM read path is built.
// Ports       : clk, rst_n               - clock, async active-low reset
//               tick_e1[N_E1-1:0]        - E1 bit ticks, one per port
//               tick_usb_sof             - USB start-of-frame pulse
//               pdm_val[N_PDM*PDM_W-1:0] - PDM values, channel i at i*PDM_W
//               pdm_oe[N_PDM-1:0]        - PDM output enables
//               boot_sel[1:0], boot_now  - reboot request fields
//               wb_*                     - Wishbone slave port
// Revision    : 1.0 - initial release
// ============================================================================
module misc_gen
    import misc_gen_pkg::*;
#(
    parameter int N_E1  = 4,
    parameter int N_PDM = 5,
    parameter int PDM_W = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_E1-1:0]        tick_e1,
    input  logic                   tick_usb_sof,
    output logic [N_PDM*PDM_W-1:0] pdm_val,
    output logic [N_PDM-1:0]       pdm_oe,
    output logic [1:0]             boot_sel,
    output logic                   boot_now,
    input  logic [7:0]             wb_addr,
    input  logic [31:0]            wb_wdata,
    output logic [31:0]            wb_rdata,
    input  logic                   wb_we,
    input  logic                   wb_cyc,
    output logic                   wb_ack
);

    // ------------------------------------------------------------------
    // Wishbone front end
    // ------------------------------------------------------------------
    logic        r_ack;
    logic [31:0] r_rdata;
    logic        r_wr_stb;
    logic [7:0]  r_wr_addr;
    logic [31:0] r_wr_data;

    logic        w_acc_start;
    logic [31:0] w_rd_mux;

    // An access starts in any cycle where cyc is high and we are not
    // already acking, so a held cyc produces back-to-back accesses.
    assign w_acc_start = wb_cyc & ~r_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack     <= 1'b0;
            r_rdata   <= '0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_ack    <= w_acc_start;
            r_rdata  <= (w_acc_start && !wb_we) ? w_rd_mux : '0;
            r_wr_stb <= w_acc_start & wb_we;
            if (w_acc_start && wb_we) begin
                r_wr_addr <= wb_addr;
                r_wr_data <= wb_wdata;
            end
        end
    end

    assign wb_ack   = r_ack;
    assign wb_rdata = r_rdata;

    // Only some write-data bits reach a register; fold the rest away.
    logic w_unused_wr_data;
    assign w_unused_wr_data = ^r_wr_data;

    // ------------------------------------------------------------------
    // Write decode (strobe is high during the ack cycle)
    // ------------------------------------------------------------------
    logic            w_wr_boot;
    logic            w_wr_status;
    logic [N_E1-1:0] w_ovf_clr;

    assign w_wr_boot   = r_wr_stb && (r_wr_addr == c_addr_boot);
    assign w_wr_status = r_wr_stb && (r_wr_addr == c_addr_status);
    assign w_ovf_clr   = w_wr_status ? r_wr_data[c_status_ovf_lsb +: N_E1] : '0;

    // ------------------------------------------------------------------
    // BOOT, TIME and SOFCNT registers
    // ------------------------------------------------------------------
    logic [1:0]  r_boot_sel;
    logic        r_boot_now;
    logic [31:0] r_time;
    logic [15:0] r_sofcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_boot_sel <= '0;
            r_boot_now <= 1'b0;
            r_time     <= '0;
            r_sofcnt   <= '0;
        end else begin
            if (w_wr_boot) begin
                r_boot_now <= r_wr_data[c_boot_now_bit];
                r_boot_sel <= r_wr_data[c_boot_sel_lsb +: 2];
            end
            r_time <= r_time + 32'd1;
            if (tick_usb_sof) begin
                r_sofcnt <= r_sofcnt + 16'd1;
            end
        end
    end

    assign boot_sel = r_boot_sel;
    assign boot_now = r_boot_now;

    // ------------------------------------------------------------------
    // Per-port tick capture channels
    // ------------------------------------------------------------------
    logic [N_E1*16-1:0] w_cap_flat;
    logic [N_E1-1:0]    w_ovf;

    for (genvar gi = 0; gi < N_E1; gi++) begin : g_tick_cap
        misc_tick_cap u_tick_cap (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick    (tick_e1[gi]),
            .sof     (tick_usb_sof),
            .ovf_clr (w_ovf_clr[gi]),
            .cap     (w_cap_flat[gi*16 +: 16]),
            .ovf     (w_ovf[gi])
        );
    end

    // ------------------------------------------------------------------
    // PDM channel registers
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N_PDM; gi++) begin : g_pdm
        logic             w_wr_pdm;
        logic [PDM_W-1:0] r_val;
        logic             r_oe;

        assign w_wr_pdm = r_wr_stb && (r_wr_addr == 8'(c_addr_pdm_base + gi));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_val <= '0;
                r_oe  <= 1'b0;
            end else if (w_wr_pdm) begin
                r_val <= r_wr_data[PDM_W-1:0];
                r_oe  <= r_wr_data[c_pdm_oe_bit];
            end
        end

        assign pdm_val[gi*PDM_W +: PDM_W] = r_val;
        assign pdm_oe[gi]                 = r_oe;
    end

    // ------------------------------------------------------------------
    // Read mux; anything not decoded here (BOOT, unmapped, ports or
    // channels beyond the configured count) reads as zero.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_mux = '0;
        if (wb_addr == c_addr_status) begin
            w_rd_mux[c_status_ovf_lsb +: N_E1] = w_ovf;
        end else if (wb_addr == c_addr_time) begin
            w_rd_mux = r_time;
        end else if (wb_addr == c_addr_sofcnt) begin
            w_rd_mux[15:0] = r_sofcnt;
        end
        for (int i = 0; i < N_E1; i++) begin
            if (wb_addr == 8'(c_addr_cap_base + i)) begin
                w_rd_mux[15:0] = w_cap_flat[i*16 +: 16];
            end
        end
`ifdef MISC_GEN_PDM_READBACK_EN
        for (int i = 0; i < N_PDM; i++) begin
            if (wb_addr == 8'(c_addr_pdm_base + i)) begin
                w_rd_mux[c_pdm_oe_bit] = pdm_oe[i];
                w_rd_mux[PDM_W-1:0]    = pdm_val[i*PDM_W +: PDM_W];
            end
        end
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_misc_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_misc_gen
// Description : Self-checking bench for misc_gen. Reads push their expected
//               value (from a behavioural register model) into a queue; a
//               monitor pops and compares whenever wb_ack presents data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_misc_gen;

    localparam int N_E1  = 4;
    localparam int N_PDM = 5;
    localparam int PDM_W = 12;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_E1-1:0]        tick_e1;
    logic                   tick_usb_sof;
    logic [N_PDM*PDM_W-1:0] pdm_val;
    logic [N_PDM-1:0]       pdm_oe;
    logic [1:0]             boot_sel;
    logic                   boot_now;
    logic [7:0]             wb_addr;
    logic [31:0]            wb_wdata;
    logic [31:0]            wb_rdata;
    logic                   wb_we;
    logic                   wb_cyc;
    logic                   wb_ack;

    always #5 clk = ~clk;

    misc_gen #(.N_E1(N_E1), .N_PDM(N_PDM), .PDM_W(PDM_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_e1      (tick_e1),
        .tick_usb_sof (tick_usb_sof),
        .pdm_val      (pdm_val),
        .pdm_oe       (pdm_oe),
        .boot_sel     (boot_sel),
        .boot_now     (boot_now),
        .wb_addr      (wb_addr),
        .wb_wdata     (wb_wdata),
        .wb_rdata     (wb_rdata),
        .wb_we        (wb_we),
        .wb_cyc       (wb_cyc),
        .wb_ack       (wb_ack)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] exp;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    // ---------------- behavioural model ----------------
    int unsigned      tcnt;          // clock edges since reset release
    int               m_int [N_E1];
    int               m_cap [N_E1];
    logic [N_E1-1:0]  m_flags;
    int               m_sof;
    logic [PDM_W-1:0] m_pdm [N_PDM];
    logic [N_PDM-1:0] m_oe;
    logic [1:0]       m_bsel;
    logic             m_bnow;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcnt <= 0;
        else        tcnt <= tcnt + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < N_E1; p++) begin m_int[p] = 0; m_cap[p] = 0; end
        for (int c = 0; c < N_PDM; c++) m_pdm[c] = '0;
        m_flags = '0; m_sof = 0; m_oe = '0; m_bsel = '0; m_bnow = 1'b0;
    endtask

    task automatic model_tick(input logic [N_E1-1:0] tv, input logic s);
        for (int p = 0; p < N_E1; p++) begin
            int nxt;
            if (tv[p] && m_int[p] == 65534) m_flags[p] = 1'b1;
            nxt = m_int[p] + (tv[p] ? 1 : 0);
            if (nxt > 65535) nxt = 65535;
            if (s) begin m_cap[p] = nxt; m_int[p] = 0; end
            else m_int[p] = nxt;
        end
        if (s) m_sof = (m_sof + 1) % 65536;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d);
        int ia = int'(a);
        if (ia == 0) begin m_bnow = d[2]; m_bsel = d[1:0]; end
        else if (ia == 1) m_flags = m_flags & ~d[N_E1-1:0];
        else if (ia >= 'h20 && ia < 'h20 + N_PDM) begin
            m_pdm[ia-'h20] = d[PDM_W-1:0];
            m_oe[ia-'h20]  = d[31];
        end
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        logic [31:0] v = '0;
        int ia = int'(a);
        if (ia == 1) v = 32'(m_flags);
        else if (ia == 2) v = tcnt;
        else if (ia == 3) v = 32'(m_sof);
        else if (ia >= 'h10 && ia < 'h10 + N_E1) v = 32'(m_cap[ia-'h10]);
`ifdef MISC_GEN_PDM_READBACK_EN
        else if (ia >= 'h20 && ia < 'h20 + N_PDM)
            v = 32'(m_pdm[ia-'h20]) | (32'(m_oe[ia-'h20]) << 31);
`endif
        return v;
    endfunction

    function automatic logic [63:0] model_pdm_vec();
        logic [63:0] v = '0;
        for (int c = 0; c < N_PDM; c++) v[c*PDM_W +: PDM_W] = m_pdm[c];
        return v;
    endfunction

    // ---------------- drivers (all start and end on a negedge) ----------------
    task automatic tick_cycle(input logic [N_E1-1:0] tv, input logic s);
        tick_e1 = tv; tick_usb_sof = s;
        model_tick(tv, s);
        @(negedge clk);
        tick_e1 = '0; tick_usb_sof = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a);
        exp_t e;
        wb_cyc = 1'b1; wb_we = 1'b0; wb_addr = a;
        e.addr = a; e.exp = model_read(a);
        exp_q.push_back(e);
        @(negedge clk);
        chk("rd_ack", 64'(wb_ack), 64'd1);
        wb_cyc = 1'b0;
        @(negedge clk);
    endtask

    // tv: ticks presented in the cycle where the write lands
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [N_E1-1:0] tv);
        wb_cyc = 1'b1; wb_we = 1'b1; wb_addr = a; wb_wdata = d;
        @(negedge clk);
        chk("wr_ack", 64'(wb_ack), 64'd1);
        chk("pdm_val_not_early", 64'(pdm_val), model_pdm_vec());
        chk("pdm_oe_not_early", 64'(pdm_oe), 64'(m_oe));
        wb_cyc = 1'b0; wb_we = 1'b0;
        tick_e1 = tv;
        model_write(a, d);
        model_tick(tv, 1'b0);
        @(negedge clk);
        tick_e1 = '0;
        chk("pdm_val", 64'(pdm_val), model_pdm_vec());
        chk("pdm_oe", 64'(pdm_oe), 64'(m_oe));
        chk("boot", 64'({boot_now, boot_sel}), 64'({m_bnow, m_bsel}));
    endtask

    task automatic read_all();
        bus_read(8'h00); bus_read(8'h01); bus_read(8'h02); bus_read(8'h03);
        for (int p = 0; p < N_E1; p++) bus_read(8'(8'h10 + p));
        for (int c = 0; c < N_PDM; c++) bus_read(8'(8'h20 + c));
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        #2;
        if (wb_ack) begin
            if (!wb_we) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_read_ack: got 0x%08h expected no ack", wb_rdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk($sformatf("rdata@%02h", mon_e.addr), 64'(wb_rdata), 64'(mon_e.exp));
                end
            end
        end else begin
            chk("rdata_idle_zero", 64'(wb_rdata), 64'd0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; tick_e1 = '0; tick_usb_sof = 1'b0;
        wb_addr = '0; wb_wdata = '0; wb_we = 1'b0; wb_cyc = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        chk("rst_ack", 64'(wb_ack), 64'd0);
        chk("rst_rdata", 64'(wb_rdata), 64'd0);
        chk("rst_pdm_val", 64'(pdm_val), 64'd0);
        chk("rst_pdm_oe", 64'(pdm_oe), 64'd0);
        chk("rst_boot", 64'({boot_now, boot_sel}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // TIME twice, 10 idle cycles apart; everything else reads 0
        bus_read(8'h02);
        repeat (10) @(negedge clk);
        bus_read(8'h02);
        read_all();

        // 37 ticks on port 2 then SOF; then 37 more with a tick in the SOF cycle
        for (int i = 0; i < 37; i++) begin
            tick_cycle(4'b0100, 1'b0);
            if ($urandom_range(0, 3) == 0) tick_cycle('0, 1'b0);
        end
        tick_cycle('0, 1'b1);
        read_all();
        for (int i = 0; i < 37; i++) tick_cycle(4'b0100, 1'b0);
        tick_cycle(4'b0100, 1'b1);
        bus_read(8'h12); bus_read(8'h03);

        // randomized ticks and SOFs
        for (int i = 0; i < 400; i++)
            tick_cycle(N_E1'($urandom), $urandom_range(0, 29) == 0);
        tick_cycle(N_E1'($urandom), 1'b1);
        read_all();

        // saturation: port 0 gets 70000 ticks, port 1 stops one short
        tick_cycle('0, 1'b1);
        for (int i = 0; i < 70000; i++)
            tick_cycle((i < 65534) ? 4'b0011 : 4'b0001, 1'b0);
        bus_read(8'h01);
        bus_write(8'h01, 32'h2, 4'b0010);   // clear collides with port 1 saturating
        bus_read(8'h01);
        bus_write(8'h01, 32'h1, '0);
        bus_read(8'h01);
        tick_cycle('0, 1'b1);
        bus_read(8'h10); bus_read(8'h11); bus_read(8'h01);
        bus_write(8'h01, 32'h2, '0);
        bus_read(8'h01);

        // PDM and BOOT
        bus_write(8'h21, 32'h80000ABC, '0);
        chk("pdm1_val", 64'(pdm_val[23:12]), 64'hABC);
        chk("pdm1_oe", 64'(pdm_oe[1]), 64'd1);
        bus_read(8'h21);
        bus_write(8'h24, $urandom, '0);
        bus_read(8'h24);
        bus_write(8'h20, 32'h7FFF_F555, '0);
        bus_read(8'h20);
        bus_write(8'h00, 32'h6, '0);
        chk("boot_now", 64'(boot_now), 64'd1);
        chk("boot_sel", 64'(boot_sel), 64'd2);
        bus_write(8'h2F, $urandom | 32'h8000_0000, '0);
        bus_write(8'h14, $urandom, '0);
        bus_read(8'h2F); bus_read(8'h14); bus_read(8'h00); bus_read(8'h7F);

        // reset pulse in the middle of a write access
        wb_cyc = 1'b1; wb_we = 1'b1; wb_addr = 8'h22; wb_wdata = 32'h8000_0123;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("abort_ack", 64'(wb_ack), 64'd0);
        @(negedge clk);
        wb_cyc = 1'b0; wb_we = 1'b0;
        chk("abort_pdm_val", 64'(pdm_val), 64'd0);
        chk("abort_pdm_oe", 64'(pdm_oe), 64'd0);
        chk("abort_boot", 64'({boot_now, boot_sel}), 64'd0);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_pdm_val", 64'(pdm_val), 64'd0);
        read_all();

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
